// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map and field positions shared by the PWM block
package pwm_pkg;

    // Avalon word addresses
    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_PERIOD   = 1;
    localparam int ADDR_PRESCALE = 2;
    localparam int ADDR_STATUS   = 3;
    localparam int ADDR_DUTY0    = 4;

    // CTRL fields: EN at bit 0, POL[ch] at bit CTRL_POL_LSB + ch
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_POL_LSB    = 1;

    // STATUS fields
    localparam int STATUS_PEND_BIT = 0;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaler and period counter with tick/wrap generation
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   en            EN as currently held in CTRL
//   en_nxt        EN as it will be after this cycle's register write
//   prescale      live PRESCALE value (no shadow)
//   per_act       active (shadowed) period
//   cnt           period counter
//   wrap          last tick of a period; cnt returns to 0
//   load_shadow   copy staging PERIOD/DUTY into the active shadows
module pwm_timebase #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             en_nxt,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] per_act,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             load_shadow
);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    always_comb begin
        tick        = en && (pre_cnt == prescale);
        wrap        = tick && (cnt == per_act);
        // Enabling loads the shadows in the CTRL write cycle so the first
        // period already runs with the programmed PERIOD/DUTY.
        load_shadow = wrap || (en_nxt && !en);
    end

    // Counters are cleared on the same edge that drops EN, so the cycle
    // after a disable already sees pre_cnt = cnt = 0 and no tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (!en_nxt) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= wrap ? '0 : cnt + CNT_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/avalon_pwm_multi.sv
// rtl/avalon_pwm_multi.sv - multi-channel edge-aligned PWM with Avalon-MM register port
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write/read request
//   readdata              combinational readback of the staging registers
//   out_port              registered PWM outputs, one per channel
module avalon_pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);

    logic              en_reg;
    logic [NUM_CH-1:0] pol_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [PRE_W-1:0]  prescale_reg;
    logic              pend;
    logic [CNT_W-1:0]  duty_reg [NUM_CH];

    logic [CNT_W-1:0]  per_act;
    logic [CNT_W-1:0]  duty_act [NUM_CH];

    logic              wr_en;
    logic              wr_ctrl;
    logic              en_nxt;
    logic [NUM_CH-1:0] pol_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic              load_shadow;
    logic [NUM_CH-1:0] active;
    logic              unused_wdata;

    // Only the low bits of writedata land in registers.
    assign unused_wdata = ^writedata;

    always_comb begin
        wr_en   = chipselect && !write_n;
        wr_ctrl = wr_en && (address == ADDR_W'(ADDR_CTRL));
        en_nxt  = wr_ctrl ? writedata[CTRL_EN_BIT] : en_reg;
        pol_nxt = wr_ctrl ? writedata[CTRL_POL_LSB +: NUM_CH] : pol_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_reg       <= 1'b0;
            pol_reg      <= '0;
            period_reg   <= '0;
            prescale_reg <= '0;
            pend         <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty_reg[i] <= '0;
        end else begin
            en_reg  <= en_nxt;
            pol_reg <= pol_nxt;
            if (wr_en && address == ADDR_W'(ADDR_PERIOD))
                period_reg <= writedata[CNT_W-1:0];
            if (wr_en && address == ADDR_W'(ADDR_PRESCALE))
                prescale_reg <= writedata[PRE_W-1:0];
            // A wrap in the same cycle as a W1C keeps PEND set.
            if (wrap)
                pend <= 1'b1;
            else if (wr_en && address == ADDR_W'(ADDR_STATUS) && writedata[STATUS_PEND_BIT])
                pend <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                if (wr_en && address == ADDR_W'(ADDR_DUTY0 + i))
                    duty_reg[i] <= writedata[CNT_W-1:0];
        end
    end

    // Shadows sample the registered staging values, so a write in the load
    // cycle is only picked up by the following load.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_act <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else if (load_shadow) begin
            per_act <= period_reg;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_reg[i];
        end
    end

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .en          (en_reg),
        .en_nxt      (en_nxt),
        .prescale    (prescale_reg),
        .per_act     (per_act),
        .cnt         (cnt),
        .wrap        (wrap),
        .load_shadow (load_shadow)
    );

    // Compare runs only while EN stays high; a disabling write forces the
    // outputs to the new POL on the same edge.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign active[g] = en_reg && en_nxt && (cnt < duty_act[g]);
    end

    always_ff @(posedge clk) begin
        if (reset) out_port <= '0;
        else       out_port <= active ^ pol_nxt;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_W'(ADDR_CTRL):     readdata = 32'({pol_reg, en_reg});
            ADDR_W'(ADDR_PERIOD):   readdata = 32'(period_reg);
            ADDR_W'(ADDR_PRESCALE): readdata = 32'(prescale_reg);
            ADDR_W'(ADDR_STATUS):   readdata = 32'(pend);
            default: begin
                for (int i = 0; i < NUM_CH; i++)
                    if (address == ADDR_W'(ADDR_DUTY0 + i))
                        readdata = 32'(duty_reg[i]);
            end
        endcase
    end

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// tb/tb_avalon_pwm_multi.sv - scoreboard bench for avalon_pwm_multi against a behavioural model
module tb_avalon_pwm_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PRE_W  = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] out_port;

    avalon_pwm_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .PRE_W  (PRE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [NUM_CH-1:0] exp_q [$];
    logic [31:0]       rd_q  [$];
    int                rd_addr_q [$];

    // Reference model state: programmed registers, the values currently in
    // force for the running period, and the position inside the period.
    int          m_en, m_pol, m_period, m_prescale, m_pend;
    int          m_duty [NUM_CH];
    int          m_per_act;
    int          m_duty_act [NUM_CH];
    int          m_pre, m_cnt;

    function automatic void model_reset();
        m_en = 0; m_pol = 0; m_period = 0; m_prescale = 0; m_pend = 0;
        m_per_act = 0; m_pre = 0; m_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            m_duty_act[i] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'(m_pol * 2 + m_en);
        if (a == 1) return 32'(m_period);
        if (a == 2) return 32'(m_prescale);
        if (a == 3) return 32'(m_pend);
        if (a >= 4 && a < 4 + NUM_CH) return 32'(m_duty[a-4]);
        return 32'd0;
    endfunction

    function automatic bit model_wrap_now();
        return m_en == 1 && m_pre == m_prescale && m_cnt == m_per_act;
    endfunction

    // One clock of the model; returns the out_port value expected after the edge.
    function automatic logic [NUM_CH-1:0] model_step(input bit wr, input int a, input logic [31:0] d);
        int  en_after, pol_after;
        bit  tick, wrap, load;
        logic [NUM_CH-1:0] o;
        en_after  = (wr && a == 0) ? int'(d[0]) : m_en;
        pol_after = (wr && a == 0) ? int'(d[NUM_CH:1]) : m_pol;
        tick = (m_en == 1) && (m_pre == m_prescale);
        wrap = tick && (m_cnt == m_per_act);
        load = wrap || (en_after == 1 && m_en == 0);
        // Channel is active for the first duty_act ticks of each period.
        for (int i = 0; i < NUM_CH; i++)
            o[i] = ((m_en == 1 && en_after == 1 && m_cnt < m_duty_act[i]) ? 1'b1 : 1'b0)
                   ^ pol_after[i];
        if (en_after == 0) begin
            m_pre = 0; m_cnt = 0;
        end else if (tick) begin
            m_pre = 0;
            m_cnt = wrap ? 0 : m_cnt + 1;
        end else begin
            m_pre = (m_pre + 1) % (1 << PRE_W);
        end
        if (load) begin
            m_per_act = m_period;
            for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty[i];
        end
        if (wrap) m_pend = 1;
        else if (wr && a == 3 && d[0]) m_pend = 0;
        if (wr) begin
            if (a == 1) m_period   = int'(d[CNT_W-1:0]);
            if (a == 2) m_prescale = int'(d[PRE_W-1:0]);
            if (a >= 4 && a < 4 + NUM_CH) m_duty[a-4] = int'(d[CNT_W-1:0]);
        end
        m_en  = en_after;
        m_pol = pol_after;
        return o;
    endfunction

    // Drive one cycle of bus activity and queue what the DUT must show.
    task automatic cyc(input bit rst, input bit cs, input bit wr, input int a, input logic [31:0] d);
        @(negedge clk);
        reset      = rst;
        chipselect = cs;
        write_n    = !(cs && wr);
        address    = ADDR_W'(a);
        writedata  = d;
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            if (cs && !wr) begin
                rd_q.push_back(model_read(a));
                rd_addr_q.push_back(a);
            end
            exp_q.push_back(model_step(cs && wr, a, d));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(0, 1, 1, a, d);
    endtask

    task automatic rd(input int a);
        cyc(0, 1, 0, a, 32'd0);
    endtask

    task automatic wait_wrap(input string what);
        int n = 0;
        while (!model_wrap_now() && n < 600) begin
            idle(1);
            n++;
        end
        if (!model_wrap_now()) begin
            total++;
            $display("FAIL %s: no wrap within %0d cycles", what, n);
        end
    endtask

    // Output monitor: one expectation per clock edge.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [NUM_CH-1:0] e;
                e = exp_q.pop_front();
                total++;
                if (out_port === e) passed++;
                else $display("FAIL out_port edge %0d: got %b expected %b", k, out_port, e);
                k++;
            end
        end
    end

    // Read monitor: readdata is combinational, sampled just after the driver sets the address.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rd_q.size() > 0) begin
                logic [31:0] e;
                int a;
                e = rd_q.pop_front();
                a = rd_addr_q.pop_front();
                total++;
                if (readdata === e) passed++;
                else $display("FAIL readdata addr %0d: got %h expected %h", a, readdata, e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        cyc(1, 0, 0, 0, 32'd0);
        cyc(1, 0, 0, 0, 32'd0);
        for (int a = 0; a < 16; a++) rd(a);

        // Basic PWM: period 10, duties 3 / 0 / 10 / 5
        wr(2, 32'd0);
        wr(1, 32'd9);
        wr(4, 32'd3);
        wr(5, 32'd0);
        wr(6, 32'd10);
        wr(7, 32'd5);
        wr(0, 32'd1);
        idle(32);

        // Double buffering: mid-period write, then a write in the wrap cycle
        wait_wrap("dbuf_mid");
        idle(4);
        wr(4, 32'd7);
        idle(3);
        wait_wrap("dbuf_exact");
        wr(4, 32'd2);
        idle(25);
        for (int a = 0; a < 8; a++) rd(a);

        // Prescale 3, period 0: wrap every 4 cycles; W1C coinciding with a set
        wr(2, 32'd3);
        wr(1, 32'd0);
        idle(12);
        wait_wrap("pend_set");
        wr(3, 32'd1);
        rd(3);
        wr(3, 32'd1);
        rd(3);
        idle(8);

        // Polarity then disable
        wr(2, 32'd0);
        wr(1, 32'd9);
        idle(12);
        wr(0, 32'h5);
        idle(14);
        wr(0, 32'h4);
        idle(4);
        rd(0);
        wr(0, 32'h5);
        idle(12);

        // Readback masking and unmapped address
        wr(1, 32'hFFFF_FFFF);
        rd(1);
        rd(15);
        rd(8);
        wr(1, 32'd6);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                2: wr(4 + int'($urandom_range(0, NUM_CH-1)), 32'($urandom_range(0, 17)));
                3: wr(1, {16'($urandom), 16'($urandom_range(0, 15))});
                4: wr(2, 32'($urandom_range(0, 3)));
                5: wr(0, {27'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0)});
                6: wr(3, 32'($urandom));
                7, 8, 9: rd(int'($urandom_range(0, 15)));
                default: idle(1);
            endcase
        end

        // Reset mid-operation with a concurrent write
        wr(0, 32'd1);
        idle(5);
        cyc(1, 1, 1, 1, 32'd5);
        cyc(1, 1, 1, 0, 32'h1F);
        for (int a = 0; a < 16; a++) rd(a);
        idle(3);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
